systolic_bus_bridge: RTL and testbench

Upstream feeder for the systolic wrapper. It accepts CPU-side valid/ready load/store requests into a small in-order command FIFO. Each request is replayed as single-cycle ren/wen strobes on the 16-bit ibus the wrapper exposes. Read data returns from the wrapper after a fixed latency and is handed back to the CPU over a valid/ready response channel.

---
 rtl/systolic_bus_bridge.sv | 144 ++++++++++++++
 tb/tb_systolic_bus_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_bus_bridge.sv
// systolic_bus_bridge: CPU-side valid/ready load/store front end for the
// systolic wrapper. Requests queue in a small in-order FIFO and are replayed
// as single-cycle ren/wen strobes on the 16-bit ibus; read data is captured
// a fixed latency after ren and returned over a valid/ready response channel.
module systolic_bus_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_we,
  input  logic [15:0] cpu_req_adr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [31:0] cpu_rsp_data,
  output logic        ren,
  output logic [15:0] ibus_radr,
  input  logic [31:0] ibus32_rdata,
  output logic        wen,
  output logic [15:0] ibus_wadr,
  output logic [31:0] ibus32_wdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RSP_HOLD = 2'd2;

  logic [15:0]   fifo_adr   [FIFO_DEPTH];
  logic [15:0]   fifo_wdata [FIFO_DEPTH];
  logic          fifo_we    [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [LW-1:0] lat_cnt;

  logic          push;
  logic          issue;
  logic          fifo_empty;
  logic          head_we;
  logic [15:0]   head_adr;
  logic [15:0]   head_wdata;

  // Upper halves of the 32-bit buses carry nothing on the 16-bit ibus.
  logic unused_upper;
  assign unused_upper = ^{cpu_req_wdata[31:16], ibus32_rdata[31:16]};

  assign cpu_req_ready = (count != CW'(FIFO_DEPTH));
  assign push          = cpu_req_valid & cpu_req_ready;
  assign fifo_empty    = (count == '0);
  // A command may leave the FIFO from IDLE, or in the very cycle the
  // pending read response is taken, so the next strobe follows the handshake
  // without a dead cycle.
  assign issue = !fifo_empty &&
                 ((state == IDLE) || ((state == RSP_HOLD) && cpu_rsp_ready));

  assign head_we    = fifo_we[rd_ptr];
  assign head_adr   = fifo_adr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];

  // FIFO storage: payload only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= cpu_req_we;
      fifo_adr[wr_ptr]   <= cpu_req_adr;
      fifo_wdata[wr_ptr] <= cpu_req_wdata[15:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Command sequencer: one-cycle strobes, single outstanding read, response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      ren           <= 1'b0;
      wen           <= 1'b0;
      ibus_radr     <= '0;
      ibus_wadr     <= '0;
      ibus32_wdata  <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_data  <= '0;
    end else begin
      ren <= 1'b0;
      wen <= 1'b0;
      case (state)
        IDLE: begin
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            cpu_rsp_data  <= {16'h0000, ibus32_rdata[15:0]};
            cpu_rsp_valid <= 1'b1;
            state         <= RSP_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RSP_HOLD: begin
          if (cpu_rsp_ready) begin
            cpu_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        if (head_we) begin
          wen          <= 1'b1;
          ibus_wadr    <= head_adr;
          ibus32_wdata <= {16'h0000, head_wdata};
        end else begin
          ren       <= 1'b1;
          ibus_radr <= head_adr;
          lat_cnt   <= LW'(RD_LAT);
          state     <= RD_WAIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_bus_bridge.sv
// tb_systolic_bus_bridge: directed bench for systolic_bus_bridge with a small
// wrapper memory model (RD_LAT = 1) and negedge logging of strobes/responses.
module tb_systolic_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [15:0] cpu_req_adr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready;
  logic [31:0] cpu_rsp_data;
  logic        ren;
  logic [15:0] ibus_radr;
  logic [31:0] ibus32_rdata;
  logic        wen;
  logic [15:0] ibus_wadr;
  logic [31:0] ibus32_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int collisions = 0;

  logic [31:0] mem     [0:255];
  logic        written [0:255] = '{default: 1'b0};

  logic [15:0] wen_adr_q  [$];
  logic [31:0] wen_data_q [$];
  int          wen_cyc_q  [$];
  logic [15:0] ren_adr_q  [$];
  logic [31:0] rsp_data_q [$];
  int          rsp_cyc_q  [$];

  systolic_bus_bridge #(.FIFO_DEPTH(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_adr(cpu_req_adr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_data(cpu_rsp_data),
    .ren(ren), .ibus_radr(ibus_radr), .ibus32_rdata(ibus32_rdata),
    .wen(wen), .ibus_wadr(ibus_wadr), .ibus32_wdata(ibus32_wdata)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp logged events.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] preload(input logic [7:0] a);
    case (a)
      8'h20:   return 32'h55AA55AA;
      8'h30:   return 32'h1234BEEF;
      default: return 32'h00000000;
    endcase
  endfunction

  // Wrapper model: writes land on the wen edge, read data is valid the cycle after ren.
  always @(posedge clk) begin
    if (wen) begin
      mem[ibus_wadr[7:0]]     <= ibus32_wdata;
      written[ibus_wadr[7:0]] <= 1'b1;
    end
    if (ren)
      ibus32_rdata <= written[ibus_radr[7:0]] ? mem[ibus_radr[7:0]] : preload(ibus_radr[7:0]);
    else
      ibus32_rdata <= 32'hDEAD0BAD;
  end

  // Event logger sampled mid-cycle.
  always @(negedge clk) begin
    if (wen) begin
      wen_adr_q.push_back(ibus_wadr);
      wen_data_q.push_back(ibus32_wdata);
      wen_cyc_q.push_back(cyc);
    end
    if (ren) ren_adr_q.push_back(ibus_radr);
    if (wen && ren) collisions <= collisions + 1;
    if (cpu_rsp_valid && cpu_rsp_ready) begin
      rsp_data_q.push_back(cpu_rsp_data);
      rsp_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [31:0] wdata);
    int waited = 0;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_adr   = adr;
    cpu_req_wdata = wdata;
    while (!cpu_req_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!cpu_req_ready) checkOutput("push_timeout", {31'b0, cpu_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag);
    int waited = 0;
    while (!cpu_rsp_valid && waited < 20) begin
      step();
      waited++;
    end
    if (!cpu_rsp_valid) checkOutput(tag, {31'b0, cpu_rsp_valid}, 32'd1);
  endtask

  initial begin
    int wb, rb, sb;
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_req_adr = '0;
    cpu_req_wdata = '0;
    cpu_rsp_ready = 1'b1;
    step(3);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_ren", {31'b0, ren}, 32'd0);
    checkOutput("rst_wen", {31'b0, wen}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, cpu_rsp_valid}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, cpu_req_ready}, 32'd1);
    checkOutput("rst_radr", {16'h0, ibus_radr}, 32'd0);
    checkOutput("rst_wadr", {16'h0, ibus_wadr}, 32'd0);
    checkOutput("rst_wdata", ibus32_wdata, 32'd0);
    checkOutput("rst_rsp_data", cpu_rsp_data, 32'd0);

    // 1. Single write
    rb = ren_adr_q.size();
    applyStimulus(1'b1, 16'h0010, 32'hABCD1234);
    checkOutput("t1_wen_early", {31'b0, wen}, 32'd0);
    step();
    checkOutput("t1_wen", {31'b0, wen}, 32'd1);
    checkOutput("t1_wadr", {16'h0, ibus_wadr}, 32'h0010);
    checkOutput("t1_wdata", ibus32_wdata, 32'h00001234);
    checkOutput("t1_ren", {31'b0, ren}, 32'd0);
    step();
    checkOutput("t1_wen_one_cycle", {31'b0, wen}, 32'd0);
    checkOutput("t1_no_ren", 32'(ren_adr_q.size() - rb), 32'd0);

    // 2. Single read
    applyStimulus(1'b0, 16'h0020, 32'h0);
    checkOutput("t2_ren_early", {31'b0, ren}, 32'd0);
    step();
    checkOutput("t2_ren", {31'b0, ren}, 32'd1);
    checkOutput("t2_radr", {16'h0, ibus_radr}, 32'h0020);
    step();
    checkOutput("t2_ren_one_cycle", {31'b0, ren}, 32'd0);
    checkOutput("t2_rsp_early", {31'b0, cpu_rsp_valid}, 32'd0);
    checkOutput("t2_radr_hold", {16'h0, ibus_radr}, 32'h0020);
    step();
    checkOutput("t2_rsp_valid", {31'b0, cpu_rsp_valid}, 32'd1);
    checkOutput("t2_rsp_data", cpu_rsp_data, 32'h000055AA);
    step();
    checkOutput("t2_rsp_clear", {31'b0, cpu_rsp_valid}, 32'd0);

    // 3. Backpressure on the response channel
    cpu_rsp_ready = 1'b0;
    wb = wen_adr_q.size();
    rb = ren_adr_q.size();
    sb = rsp_data_q.size();
    applyStimulus(1'b0, 16'h0030, 32'h0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'h0040 + 16'(i), {16'hCAFE, 16'h0100 + 16'(i)});
    checkOutput("t3_full", {31'b0, cpu_req_ready}, 32'd0);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b1;
    cpu_req_adr   = 16'h0099;
    cpu_req_wdata = 32'h00009999;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", {31'b0, cpu_rsp_valid}, 32'd1);
      checkOutput("t3_hold_data", cpu_rsp_data, 32'h0000BEEF);
      checkOutput("t3_hold_full", {31'b0, cpu_req_ready}, 32'd0);
      step();
    end
    cpu_req_valid = 1'b0;
    checkOutput("t3_no_wen", 32'(wen_adr_q.size() - wb), 32'd0);
    checkOutput("t3_one_ren", 32'(ren_adr_q.size() - rb), 32'd1);
    cpu_rsp_ready = 1'b1;
    step(10);
    checkOutput("t3_rsp_count", 32'(rsp_data_q.size() - sb), 32'd1);
    if (rsp_data_q.size() > sb) checkOutput("t3_rsp_data", rsp_data_q[sb], 32'h0000BEEF);
    checkOutput("t3_drain_count", 32'(wen_adr_q.size() - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wen_adr_q.size() > wb + i) begin
        checkOutput("t3_drain_adr", {16'h0, wen_adr_q[wb + i]}, 32'h0040 + 32'(i));
        checkOutput("t3_drain_data", wen_data_q[wb + i], 32'h00000100 + 32'(i));
      end
    end
    checkOutput("t3_ready_back", {31'b0, cpu_req_ready}, 32'd1);

    // 4. Burst of writes
    wb = wen_adr_q.size();
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_ready", {31'b0, cpu_req_ready}, 32'd1);
      applyStimulus(1'b1, 16'(i), {16'hFFFF, 16'h00A0 + 16'(i)});
    end
    step(3);
    checkOutput("t4_count", 32'(wen_adr_q.size() - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wen_adr_q.size() > wb + i) begin
        checkOutput("t4_adr", {16'h0, wen_adr_q[wb + i]}, 32'(i));
        checkOutput("t4_data", wen_data_q[wb + i], 32'h000000A0 + 32'(i));
        checkOutput("t4_consecutive", 32'(wen_cyc_q[wb + i] - wen_cyc_q[wb]), 32'(i));
      end
    end

    // 5. Mixed order W(5), R(5), W(6)
    cpu_rsp_ready = 1'b0;
    wb = wen_adr_q.size();
    sb = rsp_data_q.size();
    applyStimulus(1'b1, 16'h0005, 32'h11117777);
    applyStimulus(1'b0, 16'h0005, 32'h0);
    applyStimulus(1'b1, 16'h0006, 32'h22228888);
    waitRsp("t5_rsp_timeout");
    step(3);
    checkOutput("t5_rsp_data", cpu_rsp_data, 32'h00007777);
    checkOutput("t5_w6_held", 32'(wen_adr_q.size() - wb), 32'd1);
    cpu_rsp_ready = 1'b1;
    step(4);
    checkOutput("t5_rsp_count", 32'(rsp_data_q.size() - sb), 32'd1);
    checkOutput("t5_wen_count", 32'(wen_adr_q.size() - wb), 32'd2);
    if (wen_adr_q.size() > wb + 1 && rsp_cyc_q.size() > sb) begin
      checkOutput("t5_w6_adr", {16'h0, wen_adr_q[wb + 1]}, 32'h0006);
      checkOutput("t5_w6_data", wen_data_q[wb + 1], 32'h00008888);
      checkOutput("t5_w6_after_hs", {31'b0, wen_cyc_q[wb + 1] > rsp_cyc_q[sb]}, 32'd1);
    end

    // 6. Reset during RD_WAIT
    wb = wen_adr_q.size();
    rb = ren_adr_q.size();
    sb = rsp_data_q.size();
    applyStimulus(1'b0, 16'h0020, 32'h0);
    applyStimulus(1'b1, 16'h0050, 32'h00005050);
    step();
    rst = 1'b1;
    step();
    checkOutput("t6_ren", {31'b0, ren}, 32'd0);
    checkOutput("t6_wen", {31'b0, wen}, 32'd0);
    checkOutput("t6_rsp_valid", {31'b0, cpu_rsp_valid}, 32'd0);
    checkOutput("t6_req_ready", {31'b0, cpu_req_ready}, 32'd1);
    checkOutput("t6_rsp_data", cpu_rsp_data, 32'd0);
    rst = 1'b0;
    step(8);
    checkOutput("t6_no_rsp", 32'(rsp_data_q.size() - sb), 32'd0);
    checkOutput("t6_flushed", 32'(wen_adr_q.size() - wb), 32'd0);
    checkOutput("t6_one_ren", 32'(ren_adr_q.size() - rb), 32'd1);

    checkOutput("no_collision", 32'(collisions), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
